// File: rtl/seg_scan_ctrl.sv
// Scan controller: steps a shared 4-bit segment decoder across NUM_DIGITS digits.
// Latency: all outputs registered; a frame accepted in IDLE is committed one cycle after accept.
// Backpressure: one pending frame buffer; load_ready stays low until that frame is committed.
//
// Ports:
//   clk, rst_n   rising-edge clock, asynchronous active-low reset
//   enable       scan enable; low forces IDLE (digits off, idx=0)
//   load_valid / load_ready / load_data   frame handshake, nibble i = load_data[4i+3:4i]
//   blank_mask   1 = digit i never lit (slot time is still consumed)
//   dec_in       nibble presented to the shared decoder
//   an           digit enables, polarity set by DIG_ACTIVE_LOW
//   frame_done   one-cycle pulse in the first cycle after the last digit slot
module seg_scan_ctrl #(
  parameter int NUM_DIGITS     = 4,
  parameter int PRESCALE       = 50000,
  parameter int BLANK_CYCLES   = 16,
  parameter int DIG_ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    load_valid,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  output logic                    load_ready,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  output logic [3:0]              dec_in,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int CW          = $clog2(PRESCALE);
  localparam int IW          = $clog2(NUM_DIGITS);
  localparam int SHOW_CYCLES = PRESCALE - BLANK_CYCLES;

  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] SHOW_LAST  = CW'(SHOW_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_OFF = (DIG_ACTIVE_LOW != 0) ? '1 : '0;

  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

  state_t                  state, nxt_state;
  logic [IW-1:0]           idx, nxt_idx;
  logic [CW-1:0]           cnt, nxt_cnt;
  logic [4*NUM_DIGITS-1:0] active, pending, nxt_frame;
  logic                    frame_end, commit, accept;
  logic [NUM_DIGITS-1:0]   sel, an_lit;
  logic [3:0]              nib;

  always_comb begin
    nxt_state = state;
    nxt_idx   = idx;
    nxt_cnt   = cnt + 1'b1;
    frame_end = 1'b0;
    if (!enable) begin
      nxt_state = IDLE;
      nxt_idx   = '0;
      nxt_cnt   = '0;
    end else begin
      case (state)
        IDLE: begin
          nxt_state = BLANK;
          nxt_idx   = '0;
          nxt_cnt   = '0;
        end
        BLANK: begin
          if (cnt == BLANK_LAST) begin
            nxt_state = SHOW;
            nxt_cnt   = '0;
          end
        end
        SHOW: begin
          if (cnt == SHOW_LAST) begin
            nxt_state = BLANK;
            nxt_cnt   = '0;
            if (idx == IDX_LAST) begin
              nxt_idx   = '0;
              frame_end = 1'b1;
            end else begin
              nxt_idx = idx + 1'b1;
            end
          end
        end
        default: begin
          nxt_state = IDLE;
          nxt_idx   = '0;
          nxt_cnt   = '0;
        end
      endcase
    end

    // load_ready low means the pending buffer holds a frame.
    commit = !load_ready && (frame_end || (state == IDLE));
    accept = load_valid && load_ready;

    // The first BLANK of a frame must already see a frame committed on that same edge.
    nxt_frame = commit ? pending : active;
    nib       = nxt_frame[4*int'(nxt_idx) +: 4];

    sel          = '0;
    sel[nxt_idx] = 1'b1;
    sel          = sel & ~blank_mask;
    an_lit       = (DIG_ACTIVE_LOW != 0) ? ~sel : sel;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      cnt        <= '0;
      an         <= AN_OFF;
      dec_in     <= '0;
      load_ready <= 1'b1;
      frame_done <= 1'b0;
      active     <= '0;
      pending    <= '0;
    end else begin
      state      <= nxt_state;
      idx        <= nxt_idx;
      cnt        <= nxt_cnt;
      frame_done <= frame_end;
      an         <= (nxt_state == SHOW) ? an_lit : AN_OFF;
      if ((nxt_state == BLANK) && (state != BLANK)) begin
        dec_in <= nib;
      end
      if (commit) begin
        active     <= pending;
        load_ready <= 1'b1;
      end else if (accept) begin
        pending    <= load_data;
        load_ready <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
module tb_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        load_valid;
  logic [15:0] load_data;
  logic        load_ready;
  logic [3:0]  blank_mask;
  logic [3:0]  dec_in;
  logic [3:0]  an;
  logic        frame_done;

  int checks   = 0;
  int failures = 0;

  seg_scan_ctrl #(
    .NUM_DIGITS    (4),
    .PRESCALE      (8),
    .BLANK_CYCLES  (2),
    .DIG_ACTIVE_LOW(1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .load_valid(load_valid),
    .load_data (load_data),
    .load_ready(load_ready),
    .blank_mask(blank_mask),
    .dec_in    (dec_in),
    .an        (an),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected outputs at position pos (0..31) of a 32-cycle frame:
  // slot d = pos/8; first 2 cycles blank, then 6 cycles with digit d lit (active low).
  task automatic cyc(input logic [15:0] fr, input logic [3:0] mask, input int pos, input bit fd);
    int d, c;
    logic [3:0] exp_an, exp_dec;
    d       = pos / 8;
    c       = pos % 8;
    exp_dec = fr[4*d +: 4];
    exp_an  = (c < 2) ? 4'hF : ~((4'b0001 << d) & ~mask);
    chk($sformatf("an[f=%h,pos=%0d]", fr, pos), 32'(an), 32'(exp_an));
    chk($sformatf("dec_in[f=%h,pos=%0d]", fr, pos), 32'(dec_in), 32'(exp_dec));
    chk($sformatf("frame_done[f=%h,pos=%0d]", fr, pos), 32'(frame_done), 32'((pos == 0) && fd));
  endtask

  task automatic run_frame(input logic [15:0] fr, input logic [3:0] mask, input bit fd);
    for (int p = 0; p < 32; p++) begin
      cyc(fr, mask, p, fd);
      tick();
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    enable     = 1'b0;
    load_valid = 1'b0;
    load_data  = 16'h0000;
    blank_mask = 4'b0000;

    // Reset values
    #12;
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_dec_in", 32'(dec_in), 32'h0);
    chk("rst_load_ready", 32'(load_ready), 32'h1);
    chk("rst_frame_done", 32'(frame_done), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    chk("idle_an", 32'(an), 32'hF);

    // Load in IDLE: accept, then commit the following cycle
    load_valid = 1'b1;
    load_data  = 16'h1234;
    tick();
    load_valid = 1'b0;
    chk("idle_accept_ready", 32'(load_ready), 32'h0);
    tick();
    chk("idle_commit_ready", 32'(load_ready), 32'h1);

    // Scan: first frame from IDLE has no frame_done at its start, later ones do
    enable = 1'b1;
    tick();
    run_frame(16'h1234, 4'b0000, 1'b0);
    run_frame(16'h1234, 4'b0000, 1'b1);

    // Mid-frame load of ABCD, then 5555 offered and stalled
    for (int p = 0; p < 32; p++) begin
      cyc(16'h1234, 4'b0000, p, 1'b1);
      if (p == 5) begin
        load_valid = 1'b1;
        load_data  = 16'hABCD;
      end
      if (p == 6) begin
        chk("midframe_accept_ready", 32'(load_ready), 32'h0);
        load_data = 16'h5555;
      end
      if (p == 31) chk("stall_ready_at_frame_end", 32'(load_ready), 32'h0);
      tick();
    end

    // ABCD frame; 5555 is accepted in the frame_done cycle and waits a full frame
    for (int p = 0; p < 32; p++) begin
      cyc(16'hABCD, 4'b0000, p, 1'b1);
      if (p == 0) chk("fd_cycle_ready", 32'(load_ready), 32'h1);
      if (p == 1) begin
        chk("fd_accept_ready", 32'(load_ready), 32'h0);
        load_valid = 1'b0;
      end
      if (p == 31) chk("pending_5555_ready", 32'(load_ready), 32'h0);
      tick();
    end

    // 5555 frame with digit 2 masked
    chk("commit_5555_ready", 32'(load_ready), 32'h1);
    blank_mask = 4'b0100;
    run_frame(16'h5555, 4'b0100, 1'b1);
    blank_mask = 4'b0000;

    // Disable at 3rd SHOW cycle of digit 1
    for (int p = 0; p < 12; p++) begin
      cyc(16'h5555, 4'b0000, p, 1'b1);
      tick();
    end
    cyc(16'h5555, 4'b0000, 12, 1'b1);
    enable = 1'b0;
    tick();
    chk("disable_an", 32'(an), 32'hF);
    chk("disable_frame_done", 32'(frame_done), 32'h0);
    tick();
    chk("disable_idle_an", 32'(an), 32'hF);
    enable = 1'b1;
    tick();
    run_frame(16'h5555, 4'b0000, 1'b0);

    // Pending frame present, then reset mid-SHOW
    for (int p = 0; p < 15; p++) begin
      cyc(16'h5555, 4'b0000, p, (p == 0));
      if (p == 3) begin
        load_valid = 1'b1;
        load_data  = 16'h9876;
      end
      if (p == 4) begin
        load_valid = 1'b0;
        chk("pre_reset_pending_ready", 32'(load_ready), 32'h0);
      end
      tick();
    end
    chk("pre_reset_show_an", 32'(an), 32'hD);
    rst_n = 1'b0;
    #1;
    chk("midrst_an", 32'(an), 32'hF);
    chk("midrst_dec_in", 32'(dec_in), 32'h0);
    chk("midrst_load_ready", 32'(load_ready), 32'h1);
    chk("midrst_frame_done", 32'(frame_done), 32'h0);
    enable = 1'b0;
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    enable = 1'b1;
    tick();
    chk("post_rst_dec_in_cleared", 32'(dec_in), 32'h0);
    chk("post_rst_ready", 32'(load_ready), 32'h1);
    chk("post_rst_blank_an", 32'(an), 32'hF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
